// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one word fetch at a time to
// instruction memory over a valid/ready request/response channel, and hands
// {inst_id, pc_id} to decode over a valid/ready handshake. Downstream redirects
// replace the fetch PC; a fetch already in flight is completed and its data dropped.
// Optional feature macro: IFU_MISALIGN_CHK_EN (misaligned redirect -> ERR state,
// misalign_err port). Without it, redirect_pc[1:0] is forced to 2'b00.
module ifu #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  output logic              imem_resp_ready,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_id,
  output logic [ADDR_W-1:0] pc_id
`ifdef IFU_MISALIGN_CHK_EN
  ,output logic             misalign_err
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
`ifdef IFU_MISALIGN_CHK_EN
  localparam logic [2:0] S_ERR  = 3'd4;
`endif

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;             // next PC to fetch (redirect target while killing)
  logic [ADDR_W-1:0] req_addr, req_addr_n; // address of the request currently on the bus
  logic              kill, kill_n;         // in-flight response must be dropped
  logic [DATA_W-1:0] inst_id_n;
  logic [ADDR_W-1:0] pc_id_n;
  logic [ADDR_W-1:0] tgt;
  logic              launch;
  logic [ADDR_W-1:0] launch_addr;

  // Redirect target as the fetch stage will use it.
`ifdef IFU_MISALIGN_CHK_EN
  assign tgt = redirect_pc;
`else
  assign tgt = redirect_pc & ~ADDR_W'(3);
`endif

  assign imem_req_valid  = (state == S_REQ);
  assign imem_req_addr   = req_addr;
  assign imem_resp_ready = (state == S_WAIT);
`ifdef IFU_MISALIGN_CHK_EN
  assign inst_valid      = (state == S_HOLD) || (state == S_ERR);
  assign misalign_err    = (state == S_ERR);
`else
  assign inst_valid      = (state == S_HOLD);
`endif

  // Next-state and datapath update; 'launch' starts a fresh fetch at launch_addr.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    kill_n      = kill;
    inst_id_n   = inst_id;
    pc_id_n     = pc_id;
    launch      = 1'b0;
    launch_addr = pc;

    case (state)
      S_IDLE: begin
        launch      = 1'b1;
        launch_addr = redirect_valid ? tgt : pc;
      end
      S_REQ: begin
        // The request stays on the bus unchanged; a redirect only retargets pc.
        if (redirect_valid) begin
          pc_n   = tgt;
          kill_n = 1'b1;
        end
        if (imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (kill || redirect_valid) begin
            kill_n      = 1'b0;
            launch      = 1'b1;
            launch_addr = redirect_valid ? tgt : pc;
          end else begin
            inst_id_n = imem_resp_data;
            pc_id_n   = req_addr;
            state_n   = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_n   = tgt;
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect has priority over consumption: the held instruction is dropped.
        if (redirect_valid) begin
          launch      = 1'b1;
          launch_addr = tgt;
        end else if (inst_ready) begin
          launch      = 1'b1;
          launch_addr = pc + ADDR_W'(4);
        end
      end
`ifdef IFU_MISALIGN_CHK_EN
      S_ERR: begin
        if (redirect_valid) begin
          launch      = 1'b1;
          launch_addr = tgt;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      pc_n       = launch_addr;
      req_addr_n = launch_addr;
      state_n    = S_REQ;
`ifdef IFU_MISALIGN_CHK_EN
      // A misaligned target is never fetched; report it to decode instead.
      if (launch_addr[1:0] != 2'b00) begin
        state_n   = S_ERR;
        inst_id_n = '0;
        pc_id_n   = launch_addr;
      end
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      kill     <= 1'b0;
      inst_id  <= '0;
      pc_id    <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      kill     <= kill_n;
      inst_id  <= inst_id_n;
      pc_id    <= pc_id_n;
    end
  end

endmodule
